// File: rtl/apb_pkg.sv
// Shared APB arbiter types: FSM states, default widths
// and the round-robin pick helper.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int APB_STB_W  = 4;
    localparam int TMO_W      = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    // One requester wins outright; a tie goes to prio.
    function automatic logic rr_pick(
        input logic [1:0] req,
        input logic       prio
    );
        case (req)
            2'b10:   return 1'b1;
            2'b11:   return prio;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/apb_timeout.sv
// ACCESS-phase watchdog for the APB arbiter.
// Ports: clk, rts (sync reset), clr, en -> expired.
module apb_timeout
    import apb_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rts,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TMO_W-1:0] cnt;

    assign expired = (cnt == TMO_W'(LIMIT));

    always_ff @(posedge clk) begin
        if (rts || clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/apb_arbiter.sv
// Two-requester round-robin APB arbiter onto one slave.
// Ports: clk, rts; m_* requester side (bit/slice i
// = requester i); s_* slave side; grant, busy status.
module apb_arbiter
    import apb_pkg::*;
#(
    parameter int APB_paddr_WIDTH = APB_ADDR_W,
    parameter int DATA_WIDTH      = APB_DATA_W,
    parameter int TIMEOUT         = 255
) (
    input  logic                         clk,
    input  logic                         rts,
    input  logic [1:0]                   m_psel,
    input  logic [1:0]                   m_penable,
    input  logic [1:0]                   m_pwrite,
    input  logic [2*APB_paddr_WIDTH-1:0] m_paddr,
    input  logic [2*DATA_WIDTH-1:0]      m_pdata,
    input  logic [2*APB_STB_W-1:0]       m_pstb,
    output logic [DATA_WIDTH-1:0]        m_prdata,
    output logic [1:0]                   m_pready,
    output logic [1:0]                   m_perr,
    output logic                         s_psel,
    output logic                         s_penable,
    output logic                         s_pwrite,
    output logic [APB_paddr_WIDTH-1:0]   s_paddr,
    output logic [DATA_WIDTH-1:0]        s_pdata,
    output logic [APB_STB_W-1:0]         s_pstb,
    input  logic [DATA_WIDTH-1:0]        s_prdata,
    input  logic                         s_pready,
    input  logic                         s_perr,
    output logic                         grant,
    output logic                         busy
);

    localparam int AW = APB_paddr_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int SW = APB_STB_W;

    apb_state_t state, state_nxt;

    logic prio;
    logic win;
    logic start;
    logic done;
    logic tmo_clr;
    logic tmo_en;
    logic expired;

    // Requester phase is implied by our own FSM.
    logic penable_unused;
    assign penable_unused = ^m_penable;

    assign win   = rr_pick(m_psel, prio);
    assign start = (state == IDLE) && (|m_psel);

    assign s_psel    = (state != IDLE);
    assign s_penable = (state == ACCESS);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rts) begin
            state    <= IDLE;
            prio     <= 1'b0;
            grant    <= 1'b0;
            s_pwrite <= 1'b0;
            s_paddr  <= '0;
            s_pdata  <= '0;
            s_pstb   <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                grant    <= win;
                s_pwrite <= m_pwrite[win];
                s_paddr  <= win ? m_paddr[2*AW-1:AW]
                                : m_paddr[AW-1:0];
                s_pdata  <= win ? m_pdata[2*DW-1:DW]
                                : m_pdata[DW-1:0];
                s_pstb   <= win ? m_pstb[2*SW-1:SW]
                                : m_pstb[SW-1:0];
            end
            if (done) begin
                prio <= ~grant;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        tmo_clr   = 1'b0;
        tmo_en    = 1'b0;
        m_pready  = '0;
        m_perr    = '0;
        m_prdata  = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                state_nxt = ACCESS;
                tmo_clr   = 1'b1;
            end
            ACCESS: begin
                if (s_pready || expired) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    tmo_en = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A requester that let go, or a reset, swallows
        // the completion.
        if (done && m_psel[grant] && !rts) begin
            m_pready[grant] = 1'b1;
            m_perr[grant]   = s_pready ? s_perr : 1'b1;
            m_prdata        = s_pready ? s_prdata : '0;
        end
    end

    apb_timeout #(
        .LIMIT (TIMEOUT)
    ) u_tmo (
        .clk     (clk),
        .rts     (rts),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (expired)
    );

endmodule

// File: tb/tb_apb_arbiter.sv
// Self-checking bench for apb_arbiter: directed
// scenarios, a vector table and a random model run.
module tb_apb_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 4;

    logic          clk = 1'b0;
    logic          rts;
    logic [1:0]    m_psel, m_penable, m_pwrite;
    logic [2*AW-1:0] m_paddr;
    logic [2*DW-1:0] m_pdata;
    logic [7:0]    m_pstb;
    logic [DW-1:0] m_prdata;
    logic [1:0]    m_pready, m_perr;
    logic          s_psel, s_penable, s_pwrite;
    logic [AW-1:0] s_paddr;
    logic [DW-1:0] s_pdata;
    logic [3:0]    s_pstb;
    logic [DW-1:0] s_prdata;
    logic          s_pready, s_perr;
    logic          grant, busy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cur_w     = 0;
    int acc       = 0;

    always #5 clk = ~clk;

    apb_arbiter #(
        .APB_paddr_WIDTH (AW),
        .DATA_WIDTH      (DW),
        .TIMEOUT         (T)
    ) dut (
        .clk       (clk),
        .rts       (rts),
        .m_psel    (m_psel),
        .m_penable (m_penable),
        .m_pwrite  (m_pwrite),
        .m_paddr   (m_paddr),
        .m_pdata   (m_pdata),
        .m_pstb    (m_pstb),
        .m_prdata  (m_prdata),
        .m_pready  (m_pready),
        .m_perr    (m_perr),
        .s_psel    (s_psel),
        .s_penable (s_penable),
        .s_pwrite  (s_pwrite),
        .s_paddr   (s_paddr),
        .s_pdata   (s_pdata),
        .s_pstb    (s_pstb),
        .s_prdata  (s_prdata),
        .s_pready  (s_pready),
        .s_perr    (s_perr),
        .grant     (grant),
        .busy      (busy)
    );

    // Slave: ready after cur_w stalled ACCESS cycles.
    initial begin
        s_pready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (s_penable === 1'b1) begin
                s_pready = (acc == cur_w);
                acc++;
            end else begin
                acc = 0;
                s_pready = 1'b0;
            end
        end
    end

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h want 0x%0h",
                     nm, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [1:0] p);
        m_psel    = p;
        m_penable = p;
    endtask

    task automatic set_m(input int i,
                         input logic [31:0] a,
                         input logic [31:0] d,
                         input logic w,
                         input logic [3:0] s);
        m_paddr[i*AW +: AW] = a;
        m_pdata[i*DW +: DW] = d;
        m_pwrite[i]         = w;
        m_pstb[i*4 +: 4]    = s;
    endtask

    task automatic do_reset();
        cyc();
        rts = 1'b1;
        req(2'b00);
        m_pwrite = '0;
        m_paddr  = '0;
        m_pdata  = '0;
        m_pstb   = '0;
        s_prdata = '0;
        s_perr   = 1'b0;
        cur_w    = 0;
        cyc();
        @(negedge clk);
        chk("rst s_psel", 32'(s_psel), 0);
        chk("rst s_penable", 32'(s_penable), 0);
        chk("rst s_pwrite", 32'(s_pwrite), 0);
        chk("rst s_paddr", s_paddr, 0);
        chk("rst s_pdata", s_pdata, 0);
        chk("rst s_pstb", 32'(s_pstb), 0);
        chk("rst grant", 32'(grant), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst m_pready", 32'(m_pready), 0);
        rts = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  rq;
        int          w;
        logic        serr;
        logic [31:0] rdata;
        logic        eg;
        int          elat;
        logic        eerr;
    } vec_t;

    vec_t vt[9];

    // Random-run state
    logic        pend[2];
    logic        dprev[2];
    logic [31:0] ma[2], md[2];
    logic        mw[2];
    logic [3:0]  ms[2];

    initial begin
        int pulses;
        int lat;
        bit got;
        rts = 1'b1;
        req(2'b00);
        m_pwrite = '0;
        m_paddr  = '0;
        m_pdata  = '0;
        m_pstb   = '0;
        s_prdata = '0;
        s_perr   = 1'b0;

        // rq, w, serr, rdata, grant, latency, err
        vt[0] = '{2'b01, 0, 0, 32'h11, 0, 2, 0};
        vt[1] = '{2'b11, 1, 1, 32'h22, 1, 3, 1};
        vt[2] = '{2'b11, 0, 0, 32'h33, 0, 2, 0};
        vt[3] = '{2'b01, 2, 0, 32'h44, 0, 4, 0};
        vt[4] = '{2'b10, 0, 0, 32'h55, 1, 2, 0};
        vt[5] = '{2'b11, 8, 0, 32'h66, 0, 6, 1};
        vt[6] = '{2'b11, 3, 0, 32'h77, 1, 5, 0};
        vt[7] = '{2'b10, 0, 1, 32'h88, 1, 2, 1};
        vt[8] = '{2'b11, 0, 0, 32'h99, 0, 2, 0};

        // Zero-wait read from requester 0
        do_reset();
        cur_w = 0;
        s_prdata = 32'hDEADBEEF;
        set_m(0, 32'h100, 0, 1'b0, 4'hF);
        for (int n = 0; n < 4; n++) begin
            cyc();
            if (n == 0) req(2'b01);
            if (n == 3) req(2'b00);
            @(negedge clk);
            case (n)
                0: chk("s1 psel c0", 32'(s_psel), 0);
                1: begin
                    chk("s1 psel c1", 32'(s_psel), 1);
                    chk("s1 pen c1", 32'(s_penable), 0);
                    chk("s1 paddr", s_paddr, 32'h100);
                    chk("s1 prdata idle", m_prdata, 0);
                end
                2: begin
                    chk("s1 pen c2", 32'(s_penable), 1);
                    chk("s1 pready", 32'(m_pready), 1);
                    chk("s1 prdata", m_prdata,
                        32'hDEADBEEF);
                end
                default: chk("s1 psel c3", 32'(s_psel), 0);
            endcase
        end

        // Both request, twice
        do_reset();
        set_m(0, 32'h200, 32'h1, 1'b0, 4'hF);
        set_m(1, 32'h300, 32'h2, 1'b0, 4'hF);
        for (int n = 0; n < 7; n++) begin
            cyc();
            if (n == 0) req(2'b11);
            if (n == 3) req(2'b10);
            if (n == 6) req(2'b00);
            @(negedge clk);
            if (n <= 2)
                chk("s2 pready1 low", 32'(m_pready[1]), 0);
            if (n == 1) chk("s2 grant0", 32'(grant), 0);
            if (n == 2) chk("s2 pready r0", 32'(m_pready), 1);
            if (n == 4) begin
                chk("s2 grant1", 32'(grant), 1);
                chk("s2 paddr1", s_paddr, 32'h300);
            end
            if (n == 5) chk("s2 pready r1", 32'(m_pready), 2);
        end

        // Write from requester 1, 3 wait states
        do_reset();
        cur_w = 3;
        pulses = 0;
        set_m(1, 32'h20, 32'h55, 1'b1, 4'b0001);
        for (int n = 0; n < 9; n++) begin
            cyc();
            if (n == 0) req(2'b10);
            if (n == 6) req(2'b00);
            @(negedge clk);
            pulses += int'(m_pready[1]);
            if (n >= 2 && n <= 4) begin
                chk("s3 paddr", s_paddr, 32'h20);
                chk("s3 pdata", s_pdata, 32'h55);
                chk("s3 pstb", 32'(s_pstb), 1);
                chk("s3 pwrite", 32'(s_pwrite), 1);
                chk("s3 wait pready", 32'(m_pready), 0);
            end
            if (n == 5) chk("s3 pready", 32'(m_pready), 2);
        end
        chk("s3 pulses", pulses, 1);

        // Timeout with a slave that never answers
        do_reset();
        cur_w = 100;
        set_m(0, 32'h40, 0, 1'b0, 4'hF);
        for (int n = 0; n < 8; n++) begin
            cyc();
            if (n == 0) req(2'b01);
            if (n == 7) req(2'b00);
            @(negedge clk);
            if (n >= 2 && n <= 5) begin
                chk("s4 stall pready", 32'(m_pready), 0);
                chk("s4 stall pen", 32'(s_penable), 1);
            end
            if (n == 6) begin
                chk("s4 tmo pready", 32'(m_pready), 1);
                chk("s4 tmo perr", 32'(m_perr), 1);
            end
            if (n == 7) chk("s4 psel drop", 32'(s_psel), 0);
        end

        // Reset in second ACCESS cycle
        do_reset();
        cur_w = 1;
        set_m(0, 32'h60, 0, 1'b0, 4'hF);
        set_m(1, 32'h70, 0, 1'b0, 4'hF);
        for (int n = 0; n < 8; n++) begin
            cyc();
            if (n == 0) req(2'b01);
            if (n == 3) rts = 1'b1;
            if (n == 4) begin
                rts = 1'b0;
                cur_w = 0;
                req(2'b10);
            end
            if (n == 7) req(2'b00);
            @(negedge clk);
            if (n == 3) chk("s5 rst pready", 32'(m_pready), 0);
            if (n == 4) begin
                chk("s5 psel", 32'(s_psel), 0);
                chk("s5 busy", 32'(busy), 0);
                chk("s5 pready", 32'(m_pready), 0);
            end
            if (n == 5) begin
                chk("s5 grant", 32'(grant), 1);
                chk("s5 paddr", s_paddr, 32'h70);
            end
            if (n == 6) chk("s5 done r1", 32'(m_pready), 2);
        end

        // Requester abandons its transfer
        do_reset();
        cur_w = 1;
        set_m(0, 32'h80, 0, 1'b0, 4'hF);
        set_m(1, 32'h90, 0, 1'b0, 4'hF);
        for (int n = 0; n < 6; n++) begin
            cyc();
            if (n == 0) req(2'b01);
            if (n == 2) req(2'b00);
            if (n == 4) req(2'b11);
            @(negedge clk);
            if (n == 3) begin
                chk("s6 still sel", 32'(s_penable), 1);
                chk("s6 discard", 32'(m_pready), 0);
            end
            if (n == 4) chk("s6 psel drop", 32'(s_psel), 0);
            if (n == 5) chk("s6 next grant", 32'(grant), 1);
        end

        // Vector table
        do_reset();
        set_m(0, 32'h1000, 32'hA0, 1'b0, 4'hF);
        set_m(1, 32'h2000, 32'hB0, 1'b1, 4'h3);
        foreach (vt[k]) begin
            cur_w    = vt[k].w;
            s_perr   = vt[k].serr;
            s_prdata = vt[k].rdata;
            cyc();
            req(vt[k].rq);
            got = 0;
            lat = 0;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (|m_pready) begin
                    got = 1;
                    lat = n;
                    break;
                end
                cyc();
            end
            chk($sformatf("v%0d done", k), 32'(got), 1);
            chk($sformatf("v%0d lat", k), lat,
                vt[k].elat);
            chk($sformatf("v%0d grant", k), 32'(grant),
                32'(vt[k].eg));
            chk($sformatf("v%0d pready", k),
                32'(m_pready), 32'd1 << vt[k].eg);
            chk($sformatf("v%0d perr", k), 32'(m_perr),
                32'(vt[k].eerr) << vt[k].eg);
            if (vt[k].w <= T)
                chk($sformatf("v%0d prdata", k), m_prdata,
                    vt[k].rdata);
            cyc();
            req(2'b00);
            cyc();
        end

        // Random traffic vs transaction model
        do_reset();
        begin
            int          free, g, e, w;
            bit          act, in_x, tmo;
            logic        prio_m, win;
            logic        serr_m;
            logic [31:0] rd_m;
            free = 0; g = 0; e = 0;
            act = 0; tmo = 0;
            prio_m = 0; win = 0;
            serr_m = 0; rd_m = 0;
            for (int i = 0; i < 2; i++) begin
                pend[i]  = 0;
                dprev[i] = 0;
            end
            for (int c = 0; c < 1500; c++) begin
                cyc();
                for (int i = 0; i < 2; i++) begin
                    if (pend[i] && dprev[i]) pend[i] = 0;
                    if (!pend[i] &&
                        $urandom_range(0, 2) == 0) begin
                        pend[i] = 1;
                        ma[i] = $urandom;
                        md[i] = $urandom;
                        mw[i] = 1'($urandom_range(0, 1));
                        ms[i] = 4'($urandom_range(0, 15));
                        set_m(i, ma[i], md[i], mw[i], ms[i]);
                    end
                end
                req({pend[1], pend[0]});
                if (c >= free && (pend[0] || pend[1])) begin
                    win = (pend[0] && pend[1]) ? prio_m
                                               : pend[1];
                    w = ($urandom_range(0, 4) == 0)
                        ? 8 : int'($urandom_range(0, 3));
                    tmo = (w > T);
                    g = c;
                    e = c + 2 + (tmo ? T : w);
                    free = e + 1;
                    prio_m = ~win;
                    act = 1;
                    cur_w = w;
                    rd_m = $urandom;
                    serr_m = 1'($urandom_range(0, 1));
                    s_prdata = rd_m;
                    s_perr = serr_m;
                end
                @(negedge clk);
                in_x = act && c > g && c <= e;
                chk("r psel", 32'(s_psel), 32'(in_x));
                chk("r busy", 32'(busy), 32'(in_x));
                if (in_x) begin
                    chk("r penable", 32'(s_penable),
                        32'(c > g + 1));
                    chk("r grant", 32'(grant), 32'(win));
                    chk("r paddr", s_paddr, ma[win]);
                    chk("r pdata", s_pdata, md[win]);
                    chk("r pwrite", 32'(s_pwrite),
                        32'(mw[win]));
                    chk("r pstb", 32'(s_pstb), 32'(ms[win]));
                end
                if (in_x && c == e) begin
                    chk("r pready", 32'(m_pready),
                        32'd1 << win);
                    chk("r perr", 32'(m_perr),
                        32'(tmo ? 1'b1 : serr_m) << win);
                    if (!tmo)
                        chk("r prdata", m_prdata, rd_m);
                end else begin
                    chk("r pready idle", 32'(m_pready), 0);
                    chk("r perr idle", 32'(m_perr), 0);
                    chk("r prdata idle", m_prdata, 0);
                end
                for (int i = 0; i < 2; i++)
                    dprev[i] = in_x && c == e && win == i;
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 Parameter APB_paddr_WIDTH, 32, address width of all APB address ports.
REQ-002 Parameter DATA_WIDTH, 32, data width of all APB data ports.
REQ-003 Parameter TIMEOUT, 255, maximum ACCESS-phase cycles before the arbiter forces an error completion; legal range 1..65535.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rts  input  1  reset, synchronous, active-high.
REQ-006 m_psel  input  2  per-requester select; bit 0 = CPU, bit 1 = debug/DMA master.
REQ-007 m_penable  input  2  per-requester enable (APB access phase).
REQ-008 m_pwrite  input  2  per-requester write flag.
REQ-009 m_paddr  input  2*APB_paddr_WIDTH  per-requester address; requester i at slice i.
REQ-010 m_pdata  input  2*DATA_WIDTH  per-requester write data.
REQ-011 m_pstb  input  2*4  per-requester byte strobes.
REQ-012 m_prdata  output  DATA_WIDTH  read data, shared by both requesters.
REQ-013 m_pready  output  2  per-requester completion.
REQ-014 m_perr  output  2  per-requester error, valid only with the matching m_pready.
REQ-015 s_psel, s_penable, s_pwrite  output  1 each  slave-side APB control.
REQ-016 s_paddr  output  APB_paddr_WIDTH; s_pdata  output  DATA_WIDTH; s_pstb  output  4.
REQ-017 s_prdata  input  DATA_WIDTH; s_pready  input  1; s_perr  input  1.
REQ-018 grant  output  1  index of the owning requester; busy  output  1  high when not IDLE.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, SETUP and ACCESS.
REQ-020 IDLE: when any m_psel bit is high, the arbiter SHALL pick the winner, register the winner's paddr/pdata/pwrite/pstb onto s_*, register grant, and go to SETUP; otherwise it SHALL stay in IDLE.
REQ-021 Arbitration SHALL be round-robin: with one requester active, that requester wins; with both active, the requester indicated by the priority bit wins.
REQ-022 After each completion (normal or timeout), the priority bit SHALL point to the requester that did not win.
REQ-023 SETUP: s_psel=1 and s_penable=0; the FSM SHALL go to ACCESS unconditionally on the next edge.
REQ-024 ACCESS: s_psel=1 and s_penable=1; s_* address, data and strobes SHALL stay stable.
REQ-025 ACCESS, when s_pready=1: m_pready[grant]=s_pready and m_perr[grant]=s_perr combinationally, m_prdata=s_prdata, and the FSM SHALL return to IDLE.
REQ-026 Timeout: a cycle counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with s_pready=0.
REQ-027 When the count reaches TIMEOUT, the arbiter SHALL assert m_pready[grant]=1 and m_perr[grant]=1 for one cycle and return to IDLE; s_psel then drops on the next edge.
REQ-028 The non-granted requester SHALL see m_pready=0 and m_perr=0 at all times; it stalls by holding its request.
REQ-029 Latency: a request sampled in IDLE at cycle N SHALL complete no earlier than cycle N+2 (zero-wait slave).
REQ-030 Back-to-back transfers: m_psel still high in the IDLE cycle after a completion SHALL be treated as a new request.
REQ-031 If the granted requester drops m_psel mid-transfer, the slave transfer SHALL still complete normally and its result SHALL be discarded.
REQ-032 m_prdata SHALL be 0 whenever no m_pready bit is high.

Reset
REQ-033 When rts is high at an edge: state=IDLE, priority=requester 0, grant=0, counter=0, and s_psel, s_penable, s_pwrite, s_paddr, s_pdata and s_pstb all 0.
REQ-034 Reset in SETUP or ACCESS SHALL abort the transfer with no m_pready pulse, and s_psel SHALL be low from the next cycle.

Structure
REQ-035 The state enum (IDLE/SETUP/ACCESS) and the default APB widths SHALL live in the shared package apb_pkg.
REQ-036 The timeout counter SHALL be the single sub-module apb_timeout (inputs clr and en; output expired), 16 bits wide.

Verification
REQ-037 The bench SHALL cover each of the following directed scenarios.
REQ-038 Scenario 1: after reset, only m_psel[0] is raised with paddr=0x100, read, and s_prdata=0xDEADBEEF with a zero-wait slave -> s_psel rises at cycle 1, and at cycle 2 m_pready[0]=1 with m_prdata=0xDEADBEEF.
REQ-039 Scenario 2: both requesters request in the same cycle, twice -> the first grant is 0, the second grant is 1; m_pready[1] stays 0 during requester 0's transfer.
REQ-040 Scenario 3: requester 1 issues a write with paddr=0x20, pdata=0x55, pstb=4'b0001, and the slave waits 3 cycles -> the s_* values stay stable for all 3 wait cycles; m_pready[1] pulses exactly once.
REQ-041 Scenario 4: TIMEOUT=4 and s_pready is held at 0 -> after 4 ACCESS cycles m_pready[0]=1 and m_perr=1; the next cycle s_psel=0.
REQ-042 Scenario 5: rts is asserted in the second ACCESS cycle -> the next cycle has s_psel=0, busy=0 and no m_pready pulse; a following request from requester 1 is granted (priority back to 0, only 1 requesting).
